mem_read_responder: RTL and testbench

- Memory-side responder for the mem_read / data_ready / data_bus read handshake used by the data-capture consumer.
- Holds a small synchronous storage array, loaded through a write port.
- While the consumer holds mem_read high, returns one data word per beat: data_ready pulses for one cycle with the word on data_bus.
- Sits between the local loader and any consumer that waits on data_ready and samples data_bus.

---
 rtl/mem_resp_pkg.sv | 25 ++
 rtl/mem_resp_ram.sv | 31 +++
 rtl/mem_read_responder.sv | 109 ++++++++++
 tb/tb_mem_read_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory read responder.
// Holds the FSM state encoding and the latency counter width.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 15;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

   localparam int CNT_W = clog2(LATENCY_MAX + 1);

endpackage

// File: rtl/mem_resp_ram.sv
// DEPTH x DATA_WIDTH storage, synchronous write, registered read (read-before-write).
// Read data appears one edge after rd_en and holds until the next rd_en; no backpressure.
module mem_resp_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage is deliberately left out of reset so loads survive a reset pulse.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/mem_read_responder.sv
// Read responder: while mem_read is held, returns one word per beat with a data_ready pulse.
// First word LATENCY edges after the request sample; dropping mem_read aborts waits, not beats.
module mem_read_responder
   import mem_resp_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_read,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  data_ready,
   output logic [DATA_WIDTH-1:0] data_bus,
   output logic                  busy
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam bit               SINGLE   = (LATENCY == LATENCY_MIN);

   state_t                state;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [CNT_W-1:0]      cnt;
   logic                  ld_en;
   logic [ADDR_WIDTH-1:0] ld_addr;

   // ld_en marks every edge that enters DATA; the RAM read register is data_bus itself.
   always_comb begin
      ld_en   = 1'b0;
      ld_addr = cur_addr;
      case (state)
         IDLE: begin
            ld_en   = mem_read && SINGLE;
            ld_addr = rd_addr;
         end
         WAIT: ld_en = mem_read && (cnt == '0);
         DATA: begin
            ld_en   = mem_read && SINGLE;
            ld_addr = cur_addr + ADDR_WIDTH'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cur_addr   <= '0;
         cnt        <= '0;
         data_ready <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_ready <= ld_en;
         case (state)
            IDLE: begin
               if (mem_read) begin
                  cur_addr <= rd_addr;
                  cnt      <= CNT_LOAD;
                  state    <= SINGLE ? DATA : WAIT;
                  busy     <= 1'b1;
               end
            end
            WAIT: begin
               if (!mem_read) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (cnt == '0) begin
                  state <= DATA;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DATA: begin
               if (mem_read) begin
                  cur_addr <= ld_addr;
                  cnt      <= CNT_LOAD;
                  state    <= SINGLE ? DATA : WAIT;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   mem_resp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (ld_en),
      .rd_addr (ld_addr),
      .rd_data (data_bus)
   );

endmodule

// File: tb/tb_mem_read_responder.sv
// Bench for mem_read_responder: LATENCY=2 and LATENCY=3 instances share all inputs.
// Reference model works from elapsed edges since burst start rather than FSM states.
module tb_mem_read_responder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mem_read;
   logic [3:0] rd_addr;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       r2, y2, r3, y3;
   logic [7:0] b2, b3;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_read_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LATENCY(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .rd_addr(rd_addr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .data_ready(r2), .data_bus(b2), .busy(y2));

   mem_read_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .rd_addr(rd_addr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .data_ready(r3), .data_bus(b3), .busy(y3));

   // Reference model: index 0 models LATENCY=2, index 1 models LATENCY=3.
   bit [7:0] m_mem [16];
   bit       m_act [2];
   bit       m_rdy [2];
   bit [7:0] m_bus [2];
   bit [3:0] m_base[2];
   int       m_el  [2];
   int       ml;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0;
            m_rdy[i] = 1'b0;
            m_bus[i] = 8'h00;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            ml = i + 2;
            if (!m_act[i]) begin
               if (mem_read) begin
                  m_act[i]  = 1'b1;
                  m_el[i]   = 0;
                  m_base[i] = rd_addr;
               end
            end else begin
               m_el[i] = m_el[i] + 1;
               if (!mem_read) m_act[i] = 1'b0;
            end
            // Beats fall at LATENCY, then every LATENCY+1 edges after the start.
            m_rdy[i] = m_act[i] && (m_el[i] >= ml) && ((m_el[i] - ml) % (ml + 1) == 0);
            if (m_rdy[i]) m_bus[i] = m_mem[4'(int'(m_base[i]) + (m_el[i] - ml) / (ml + 1))];
         end
      end
      if (clk && wr_en) m_mem[wr_addr] = wr_data;
   end

   wire [19:0] dut_vec = {r2, b2, y2, r3, b3, y3};
   wire [19:0] mdl_vec = {m_rdy[0], m_bus[0], m_act[0], m_rdy[1], m_bus[1], m_act[1]};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; mem_read = 1'b0; rd_addr = 4'd0; wr_en = 1'b1;
      for (int a = 0; a < 16; a++) begin
         wr_addr = 4'(a);
         wr_data = 8'($urandom);
         tick();
         n_cmp++;
         if (dut_vec !== 20'h0) begin
            n_bad++; $display("FAIL reset_hold a=%0d got=%h want=%h", a, dut_vec, 20'h0);
         end
      end
      wr_en = 1'b0;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if (dut_vec !== 20'h0) begin
            n_bad++; $display("FAIL reset_idle c=%0d got=%h want=%h", c, dut_vec, 20'h0);
         end
      end
   endtask

   task automatic test_single;
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
      tick();
      wr_en = 1'b0; mem_read = 1'b1; rd_addr = 4'd3;
      for (int c = 0; c < 8; c++) begin
         if (c == 3) mem_read = 1'b0;
         tick();
         n_cmp++;
         if (dut_vec !== mdl_vec) begin
            n_bad++; $display("FAIL single c=%0d got=%h want=%h", c, dut_vec, mdl_vec);
         end
         if (c == 1) begin
            n_cmp++;
            if (r2 !== 1'b0) begin
               n_bad++; $display("FAIL single_early got=%b want=0", r2);
            end
         end
         if (c == 2) begin
            n_cmp++;
            if ({r2, b2} !== {1'b1, 8'hA5}) begin
               n_bad++; $display("FAIL single_beat got=%b/%h want=1/a5", r2, b2);
            end
         end
         if (c == 3) begin
            n_cmp++;
            if ({r2, y2} !== 2'b00) begin
               n_bad++; $display("FAIL single_idle got=%b%b want=00", r2, y2);
            end
         end
      end
   endtask

   task automatic test_burst_wrap;
      logic [7:0] beat_dat [$];
      int         beat_cyc [$];
      bit [7:0]   want [3];
      want = '{8'h11, 8'h22, 8'h33};
      wr_en = 1'b1;
      wr_addr = 4'd14; wr_data = 8'h11; tick();
      wr_addr = 4'd15; wr_data = 8'h22; tick();
      wr_addr = 4'd0;  wr_data = 8'h33; tick();
      wr_en = 1'b0; mem_read = 1'b1; rd_addr = 4'd14;
      for (int c = 0; c < 12; c++) begin
         if (c == 9) mem_read = 1'b0;
         else if (c > 0) rd_addr = 4'($urandom);
         tick();
         n_cmp++;
         if (dut_vec !== mdl_vec) begin
            n_bad++; $display("FAIL burst c=%0d got=%h want=%h", c, dut_vec, mdl_vec);
         end
         if (r2 === 1'b1) begin
            beat_dat.push_back(b2);
            beat_cyc.push_back(c);
         end
      end
      n_cmp++;
      if (beat_dat.size() != 3) begin
         n_bad++; $display("FAIL burst_count got=%0d want=3", beat_dat.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (beat_dat[i] !== want[i]) begin
               n_bad++; $display("FAIL burst_word%0d got=%h want=%h", i, beat_dat[i], want[i]);
            end
         end
         for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (beat_cyc[i] - beat_cyc[i-1] != 3) begin
               n_bad++; $display("FAIL burst_gap%0d got=%0d want=3", i, beat_cyc[i] - beat_cyc[i-1]);
            end
         end
      end
   endtask

   task automatic test_abort;
      wr_en = 1'b1;
      wr_addr = 4'd5; wr_data = 8'h5A; tick();
      wr_addr = 4'd6; wr_data = 8'hC3; tick();
      wr_en = 1'b0; mem_read = 1'b1; rd_addr = 4'd5;
      for (int c = 0; c < 7; c++) begin
         if (c == 4) mem_read = 1'b0;
         tick();
         n_cmp++;
         if (dut_vec !== mdl_vec) begin
            n_bad++; $display("FAIL abort_setup c=%0d got=%h want=%h", c, dut_vec, mdl_vec);
         end
      end
      mem_read = 1'b1; rd_addr = 4'd6;
      tick();
      n_cmp++;
      if (y3 !== 1'b1) begin
         n_bad++; $display("FAIL abort_busy got=%b want=1", y3);
      end
      mem_read = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_cmp++;
         if ({r3, b3, y3} !== {1'b0, 8'h5A, 1'b0}) begin
            n_bad++; $display("FAIL abort c=%0d got=%b/%h/%b want=0/5a/0", c, r3, b3, y3);
         end
         n_cmp++;
         if (dut_vec !== mdl_vec) begin
            n_bad++; $display("FAIL abort_model c=%0d got=%h want=%h", c, dut_vec, mdl_vec);
         end
      end
   endtask

   task automatic test_collision;
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h10;
      tick();
      wr_en = 1'b0; mem_read = 1'b1; rd_addr = 4'd2;
      for (int c = 0; c < 6; c++) begin
         wr_en = (c == 2); wr_data = 8'h20;
         if (c == 3) mem_read = 1'b0;
         tick();
         n_cmp++;
         if (dut_vec !== mdl_vec) begin
            n_bad++; $display("FAIL collide c=%0d got=%h want=%h", c, dut_vec, mdl_vec);
         end
         if (c == 2) begin
            n_cmp++;
            if ({r2, b2} !== {1'b1, 8'h10}) begin
               n_bad++; $display("FAIL collide_old got=%b/%h want=1/10", r2, b2);
            end
         end
      end
      wr_en = 1'b0; mem_read = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) mem_read = 1'b0;
         tick();
         if (c == 2) begin
            n_cmp++;
            if ({r2, b2} !== {1'b1, 8'h20}) begin
               n_bad++; $display("FAIL collide_new got=%b/%h want=1/20", r2, b2);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      mem_read = 1'b1; rd_addr = 4'd7;
      tick();
      tick();
      n_cmp++;
      if ({r2, y2, r3, y3} !== 4'b0101) begin
         n_bad++; $display("FAIL midrst_wait got=%b want=0101", {r2, y2, r3, y3});
      end
      @(negedge clk);
      rst_n = 1'b0; mem_read = 1'b0;
      #1;
      n_cmp++;
      if (dut_vec !== 20'h0) begin
         n_bad++; $display("FAIL midrst_async got=%h want=%h", dut_vec, 20'h0);
      end
      tick();
      rst_n = 1'b1;
      tick();
      mem_read = 1'b1; rd_addr = 4'd0;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) mem_read = 1'b0;
         tick();
         n_cmp++;
         if (dut_vec !== mdl_vec) begin
            n_bad++; $display("FAIL midrst c=%0d got=%h want=%h", c, dut_vec, mdl_vec);
         end
         if (c == 2) begin
            n_cmp++;
            if ({r2, b2} !== {1'b1, 8'h33}) begin
               n_bad++; $display("FAIL midrst_read got=%b/%h want=1/33", r2, b2);
            end
         end
      end
   endtask

   task automatic test_random;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(7) == 0) mem_read = ~mem_read;
         rd_addr = 4'($urandom);
         wr_en   = ($urandom_range(3) == 0);
         wr_addr = 4'($urandom);
         wr_data = 8'($urandom);
         rst_n   = ($urandom_range(79) != 0);
         tick();
         n_cmp++;
         if (dut_vec !== mdl_vec) begin
            n_bad++; $display("FAIL random c=%0d got=%h want=%h", c, dut_vec, mdl_vec);
         end
      end
      rst_n = 1'b1; mem_read = 1'b0; wr_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst_wrap();
      test_abort();
      test_collision();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
